// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 3-bit words go out MSB first in back-to-back frames,
// aligned to the sequence detector's Start/bit1/bit2 framing.
module seq_frame_tx #(
    parameter int          CNT_W     = 8,
    parameter logic [2:0]  IDLE_WORD = 3'b000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             guard_en,
    output logic             Dout,
    output logic             frame_start,
    output logic [1:0]       bit_index,
    output logic             subst_flag,
    output logic             err_pred,
    output logic [CNT_W-1:0] frame_count
);

    generate
        if (IDLE_WORD == 3'b111) begin : g_bad_idle
            $error("seq_frame_tx: IDLE_WORD must not be the forbidden frame 3'b111");
        end
    endgenerate

    typedef enum logic [1:0] {
        BIT0 = 2'd0,
        BIT1 = 2'd1,
        BIT2 = 2'd2
    } bit_e;

    bit_e             state_q, state_d;
    logic [2:0]       fr_q, fr_d;
    logic             subst_q, subst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= BIT0;
            fr_q    <= IDLE_WORD;
            subst_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fr_q    <= fr_d;
            subst_q <= subst_d;
            cnt_q   <= cnt_d;
        end
    end

    // The next frame is loaded only at the last bit edge, so the line never bubbles.
    always_comb begin
        state_d     = BIT0;
        fr_d        = fr_q;
        subst_d     = subst_q;
        cnt_d       = cnt_q;
        Dout        = fr_q[0];
        frame_start = 1'b0;
        data_ready  = 1'b0;
        err_pred    = 1'b0;
        case (state_q)
            BIT0: begin
                state_d     = BIT1;
                Dout        = fr_q[2];
                frame_start = 1'b1;
            end
            BIT1: begin
                state_d = BIT2;
                Dout    = fr_q[1];
            end
            BIT2: begin
                state_d    = BIT0;
                Dout       = fr_q[0];
                data_ready = 1'b1;
                err_pred   = (fr_q == 3'b111);
                cnt_d      = cnt_q + CNT_W'(1);
                subst_d    = 1'b0;
                if (data_valid) begin
                    if (guard_en && (data_in == 3'b111)) begin
                        fr_d    = 3'b110;
                        subst_d = 1'b1;
                    end else begin
                        fr_d = data_in;
                    end
                end else begin
                    fr_d = IDLE_WORD;
                end
            end
            default: state_d = BIT0;
        endcase
    end

    assign bit_index   = state_q;
    assign subst_flag  = subst_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: idle framing, accept latency, back-to-back
// words, forbidden-frame guard, mid-frame reset and counter wrap.
module tb_seq_frame_tx;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] data_in;
    logic       data_valid;
    logic       guard_en;
    logic       data_ready, Dout, frame_start, subst_flag, err_pred;
    logic [1:0] bit_index;
    logic [7:0] frame_count;

    logic       rdy2, dout2, fs2, sub2, err2;
    logic [1:0] bi2;
    logic [1:0] fc2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    seq_frame_tx #(.CNT_W(8), .IDLE_WORD(3'b000)) dut (
        .Clock(Clock), .Reset(Reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .guard_en(guard_en), .Dout(Dout),
        .frame_start(frame_start), .bit_index(bit_index), .subst_flag(subst_flag),
        .err_pred(err_pred), .frame_count(frame_count)
    );

    seq_frame_tx #(.CNT_W(2), .IDLE_WORD(3'b000)) dut2 (
        .Clock(Clock), .Reset(Reset), .data_in(3'b000), .data_valid(1'b0),
        .data_ready(rdy2), .guard_en(1'b0), .Dout(dout2),
        .frame_start(fs2), .bit_index(bi2), .subst_flag(sub2),
        .err_pred(err2), .frame_count(fc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Stream check of one cycle: line bit, frame start and error prediction.
    task automatic chk_line(input string tag, input logic d, input logic fs, input logic e);
        chk({tag, ".Dout"}, 32'(Dout), 32'(d));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
        chk({tag, ".err_pred"}, 32'(err_pred), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        logic [8:0] stream;
        logic [2:0] words [3];

        Reset      = 1'b0;
        data_in    = 3'b000;
        data_valid = 1'b0;
        guard_en   = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("rst.Dout", 32'(Dout), 32'd0);
        chk("rst.frame_start", 32'(frame_start), 32'd1);
        chk("rst.data_ready", 32'(data_ready), 32'd0);
        chk("rst.err_pred", 32'(err_pred), 32'd0);
        chk("rst.bit_index", 32'(bit_index), 32'd0);
        chk("rst.frame_count", 32'(frame_count), 32'd0);
        chk("rst.subst_flag", 32'(subst_flag), 32'd0);
        Reset = 1'b1;

        // idle frames straight out of reset
        for (int c = 0; c < 12; c++) begin
            chk_line("idle", 1'b0, (c % 3) == 0, 1'b0);
            chk("idle.data_ready", 32'(data_ready), 32'((c % 3) == 2));
            chk("idle.frame_count", 32'(frame_count), 32'(c / 3));
            chk("idle.bit_index", 32'(bit_index), 32'(c % 3));
            step();
        end
        chk("idle.frame_count_end", 32'(frame_count), 32'd4);

        // single word 101 offered from reset
        data_in    = 3'b101;
        data_valid = 1'b1;
        do_reset();
        chk_line("w101.c0", 1'b0, 1'b1, 1'b0);
        step();
        chk_line("w101.c1", 1'b0, 1'b0, 1'b0);
        step();
        chk("w101.ready", 32'(data_ready), 32'd1);
        step();
        data_valid = 1'b0;
        chk_line("w101.b2", 1'b1, 1'b1, 1'b0);
        chk("w101.count", 32'(frame_count), 32'd1);
        step();
        chk_line("w101.b1", 1'b0, 1'b0, 1'b0);
        step();
        chk_line("w101.b0", 1'b1, 1'b0, 1'b0);
        step();

        // back-to-back 110, 011, 100 with valid held
        words[0] = 3'b110;
        words[1] = 3'b011;
        words[2] = 3'b100;
        stream   = 9'b110_011_100;
        data_in    = words[0];
        data_valid = 1'b1;
        step();
        step();
        chk("b2b.ready", 32'(data_ready), 32'd1);
        step();
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) begin
                if (i / 3 < 2) data_in = words[i / 3 + 1];
                else           data_valid = 1'b0;
            end
            chk_line("b2b", stream[8 - i], (i % 3) == 0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk_line("b2b.idle", 1'b0, i == 0, 1'b0);
            step();
        end

        // 111 unguarded, then 111 guarded
        data_in    = 3'b111;
        data_valid = 1'b1;
        guard_en   = 1'b0;
        step();
        step();
        step();
        guard_en = 1'b1;
        chk_line("raw111.b2", 1'b1, 1'b1, 1'b0);
        chk("raw111.subst", 32'(subst_flag), 32'd0);
        step();
        chk_line("raw111.b1", 1'b1, 1'b0, 1'b0);
        step();
        chk_line("raw111.b0", 1'b1, 1'b0, 1'b1);
        step();
        data_valid = 1'b0;
        guard_en   = 1'b0;
        chk_line("grd111.b2", 1'b1, 1'b1, 1'b0);
        chk("grd111.subst0", 32'(subst_flag), 32'd1);
        step();
        chk_line("grd111.b1", 1'b1, 1'b0, 1'b0);
        chk("grd111.subst1", 32'(subst_flag), 32'd1);
        step();
        chk_line("grd111.b0", 1'b0, 1'b0, 1'b0);
        chk("grd111.subst2", 32'(subst_flag), 32'd1);
        step();
        chk_line("grd111.after", 1'b0, 1'b1, 1'b0);
        chk("grd111.subst_clr", 32'(subst_flag), 32'd0);

        // reset in the middle of word 101
        data_in    = 3'b101;
        data_valid = 1'b1;
        step();
        step();
        step();
        data_valid = 1'b0;
        chk("mid.Dout_b2", 32'(Dout), 32'd1);
        step();
        chk("mid.bit_index_pre", 32'(bit_index), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid.Dout", 32'(Dout), 32'd0);
        chk("mid.bit_index", 32'(bit_index), 32'd0);
        chk("mid.frame_count", 32'(frame_count), 32'd0);
        chk("mid.subst_flag", 32'(subst_flag), 32'd0);
        chk("mid.frame_start", 32'(frame_start), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk_line("mid.idle", 1'b0, (c % 3) == 0, 1'b0);
            chk("mid.idle_count", 32'(frame_count), 32'(c / 3));
            step();
        end
        data_in    = 3'b011;
        data_valid = 1'b1;
        step();
        step();
        step();
        data_valid = 1'b0;
        chk_line("mid.resend.b2", 1'b0, 1'b1, 1'b0);
        step();
        chk_line("mid.resend.b1", 1'b1, 1'b0, 1'b0);
        step();
        chk_line("mid.resend.b0", 1'b1, 1'b0, 1'b0);

        // narrow counter wrap: 1,2,3,0,1
        do_reset();
        for (int c = 0; c < 16; c++) begin
            chk("wrap.frame_count", 32'(fc2), 32'((c / 3) % 4));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
